// File: rtl/serial_to_parallel_if.sv
// serial_to_parallel_if: serial input and parallel word output bundle
interface serial_to_parallel_if #(parameter int WIDTH = 4);
  logic             start;
  logic             ser_valid;
  logic             ser_in;
  logic [WIDTH-1:0] data_out;
  logic             data_ready;
  logic             parity_err;
  logic             busy;
  modport master (output start, ser_valid, ser_in, input data_out, data_ready, parity_err, busy);
  modport slave  (input start, ser_valid, ser_in, output data_out, data_ready, parity_err, busy);
endinterface

// File: rtl/serial_to_parallel.sv
// serial_to_parallel: framed serial bits to WIDTH-bit word with optional even parity
module serial_to_parallel #(
  parameter int WIDTH     = 4,
  parameter int MSB_FIRST = 1,
  parameter int PARITY_EN = 0
) (
  input logic                 clk,
  input logic                 reset,
  serial_to_parallel_if.slave bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  typedef enum logic [1:0] {IDLE, DATA, PARITY} state_t;
  state_t           state, state_n;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] shreg, shift_n, data_out;
  logic             data_ready, parity_err, busy, last_bit;
  assign last_bit = count == CW'(WIDTH - 1);
  assign shift_n  = (MSB_FIRST != 0) ? {shreg[WIDTH-2:0], bus.ser_in} : {bus.ser_in, shreg[WIDTH-1:1]};
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  // start overrides everything, including a bit arriving in the same cycle
  always_comb begin
    state_n = state;
    state_n = bus.start ? DATA
            : (state == DATA && bus.ser_valid && last_bit) ? ((PARITY_EN != 0) ? PARITY : IDLE)
            : (state == PARITY && bus.ser_valid) ? IDLE
            : state;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      count      <= '0;
      shreg      <= '0;
      data_out   <= '0;
      data_ready <= 1'b0;
      parity_err <= 1'b0;
      busy       <= 1'b0;
    end else begin
      data_ready <= 1'b0;
      parity_err <= 1'b0;
      busy       <= state_n != IDLE;
      if (bus.start) begin
        count <= '0;
        shreg <= '0;
      end else if (bus.ser_valid && state == DATA) begin
        shreg <= shift_n;
        count <= last_bit ? '0 : count + CW'(1);
        if (last_bit && PARITY_EN == 0) begin
          data_out   <= shift_n;
          data_ready <= 1'b1;
        end
      end else if (bus.ser_valid && state == PARITY) begin
        if (^{shreg, bus.ser_in}) parity_err <= 1'b1;
        else begin
          data_out   <= shreg;
          data_ready <= 1'b1;
        end
      end
    end
  assign bus.data_out   = data_out;
  assign bus.data_ready = data_ready;
  assign bus.parity_err = parity_err;
  assign bus.busy       = busy;
endmodule

// File: tb/tb_serial_to_parallel.sv
// tb_serial_to_parallel: three configurations driven in lockstep, checked against a frame-level model
module tb_serial_to_parallel;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0, ser_valid = 1'b0, ser_in = 1'b0;
  int n_chk = 0, n_pass = 0;
  always #5 clk = ~clk;
  serial_to_parallel_if #(.WIDTH(4)) ia ();
  serial_to_parallel_if #(.WIDTH(4)) ib ();
  serial_to_parallel_if #(.WIDTH(4)) ic ();
  assign ia.start = start;  assign ia.ser_valid = ser_valid;  assign ia.ser_in = ser_in;
  assign ib.start = start;  assign ib.ser_valid = ser_valid;  assign ib.ser_in = ser_in;
  assign ic.start = start;  assign ic.ser_valid = ser_valid;  assign ic.ser_in = ser_in;
  serial_to_parallel #(.WIDTH(4), .MSB_FIRST(1), .PARITY_EN(0)) dut_a (.clk(clk), .reset(reset), .bus(ia));
  serial_to_parallel #(.WIDTH(4), .MSB_FIRST(0), .PARITY_EN(0)) dut_b (.clk(clk), .reset(reset), .bus(ib));
  serial_to_parallel #(.WIDTH(4), .MSB_FIRST(1), .PARITY_EN(1)) dut_c (.clk(clk), .reset(reset), .bus(ic));
  // model: a frame is a list of received bits; it completes when 4 (+parity) bits are in
  logic [3:0] m_data [3];
  bit         m_rdy [3], m_err [3], m_frame [3];
  bit [4:0]   m_bits [3];
  int         m_n [3];
  function automatic bit is_msb(int k); return k != 1; endfunction
  function automatic bit has_par(int k); return k == 2; endfunction
  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_data[k] = '0; m_rdy[k] = 0; m_err[k] = 0; m_frame[k] = 0; m_n[k] = 0; m_bits[k] = '0;
    end
  endtask
  task automatic model_edge();
    for (int k = 0; k < 3; k++) begin
      m_rdy[k] = 0; m_err[k] = 0;
      if (start) begin
        m_frame[k] = 1; m_n[k] = 0;
      end else if (m_frame[k] && ser_valid) begin
        m_bits[k][m_n[k]] = ser_in;
        m_n[k]++;
        if (m_n[k] == 4 + int'(has_par(k))) begin
          bit x = 0;
          logic [3:0] w = '0;
          m_frame[k] = 0;
          for (int i = 0; i < m_n[k]; i++) x ^= m_bits[k][i];
          for (int i = 0; i < 4; i++) w[is_msb(k) ? 3 - i : i] = m_bits[k][i];
          if (has_par(k) && x) m_err[k] = 1;
          else begin m_data[k] = w; m_rdy[k] = 1; end
        end
      end
    end
  endtask
  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask
  function automatic logic [7:0] pack(logic [3:0] d, logic r, logic e, logic b);
    return {1'b0, d, r, e, b};
  endfunction
  task automatic check_all(string tag);
    chk({tag, "/A"}, pack(ia.data_out, ia.data_ready, ia.parity_err, ia.busy), pack(m_data[0], m_rdy[0], m_err[0], m_frame[0]));
    chk({tag, "/B"}, pack(ib.data_out, ib.data_ready, ib.parity_err, ib.busy), pack(m_data[1], m_rdy[1], m_err[1], m_frame[1]));
    chk({tag, "/C"}, pack(ic.data_out, ic.data_ready, ic.parity_err, ic.busy), pack(m_data[2], m_rdy[2], m_err[2], m_frame[2]));
  endtask
  task automatic step(bit s, bit v, bit b, string tag);
    start = s; ser_valid = v; ser_in = b;
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask
  task automatic frame(bit [4:0] bits, int n, string tag);
    step(1, 0, 0, tag);
    for (int i = n - 1; i >= 0; i--) step(0, 1, bits[i], tag);
  endtask
  task automatic async_reset(string tag);
    #2 reset = 1'b1;
    #1 model_reset();
    check_all(tag);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask
  typedef struct { bit s, v, b; logic [3:0] da; bit ra, busy; logic [3:0] db; } vec_t;
  vec_t tv [6];
  initial begin
    tv[0] = '{1, 0, 0, 4'b0000, 0, 1, 4'b0000};
    tv[1] = '{0, 1, 1, 4'b0000, 0, 1, 4'b0000};
    tv[2] = '{0, 1, 0, 4'b0000, 0, 1, 4'b0000};
    tv[3] = '{0, 1, 1, 4'b0000, 0, 1, 4'b0000};
    tv[4] = '{0, 1, 1, 4'b1011, 1, 0, 4'b1101};
    tv[5] = '{0, 0, 0, 4'b1011, 0, 0, 4'b1101};
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_all("reset");
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(tv[i].s, tv[i].v, tv[i].b, "tbl");
      chk($sformatf("tbl%0d_a", i), pack(ia.data_out, ia.data_ready, 1'b0, ia.busy), pack(tv[i].da, tv[i].ra, 1'b0, tv[i].busy));
      chk($sformatf("tbl%0d_b", i), {4'b0, ib.data_out}, {4'b0, tv[i].db});
    end
    frame(5'b10111, 5, "par_ok");
    chk("par_ok_c", pack(ic.data_out, ic.data_ready, ic.parity_err, 1'b0), pack(4'b1011, 1'b1, 1'b0, 1'b0));
    step(0, 0, 0, "idle");
    frame(5'b01110, 5, "par_bad");
    chk("par_bad_c", pack(ic.data_out, ic.data_ready, ic.parity_err, 1'b0), pack(4'b1011, 1'b0, 1'b1, 1'b0));
    step(1, 0, 0, "abort"); step(0, 1, 1, "abort"); step(0, 1, 1, "abort");
    frame(5'b00001, 4, "abort");
    chk("abort_a", pack(ia.data_out, ia.data_ready, 1'b0, ia.busy), pack(4'b0001, 1'b1, 1'b0, 1'b0));
    step(1, 0, 0, "rst"); step(0, 1, 0, "rst"); step(0, 1, 1, "rst");
    async_reset("rst_async");
    chk("rst_zero_a", pack(ia.data_out, ia.data_ready, ia.parity_err, ia.busy), 8'h00);
    frame(5'b00110, 4, "after_rst");
    chk("after_rst_a", pack(ia.data_out, ia.data_ready, 1'b0, 1'b0), pack(4'b0110, 1'b1, 1'b0, 1'b0));
    step(1, 0, 0, "gap");
    for (int i = 3; i >= 0; i--) begin
      logic [3:0] w = 4'b1001;
      step(0, 1, w[i], "gap");
      if (i > 0) for (int g = 0; g < 3; g++) begin
        step(0, 0, 0, "gap");
        chk("gap_busy", {7'b0, ia.busy}, 8'h01);
      end
    end
    chk("gap_a", {4'b0, ia.data_out}, 8'h09);
    step(1, 1, 1, "drop");
    for (int i = 0; i < 4; i++) step(0, 1, 0, "drop");
    chk("drop_a", pack(ia.data_out, ia.data_ready, 1'b0, 1'b0), pack(4'b0000, 1'b1, 1'b0, 1'b0));
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 199) == 0) async_reset("rnd_rst");
      else step($urandom_range(0, 19) == 0, $urandom_range(0, 9) < 6, 1'($urandom), "rnd");
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
